jtag_tap_param: RTL and testbench

Parametrised IEEE 1149.1 test access port: a full 16-state TAP controller, an instruction register, and the BYPASS and IDCODE data registers, plus NUM_USER_DR user data-register channels with capture/update handshakes to core debug logic. It sits between the chip JTAG pins and the core debug block. It is the generalised successor to the fixed TAP FSM wrapper.

---
 rtl/jtag_tap_param.sv | 167 ++++++++++++++++
 tb/tb_jtag_tap_param.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_param.sv
// Parametrised IEEE 1149.1 TAP: 16-state controller, instruction register,
// BYPASS/IDCODE data registers and NUM_USER_DR user channels for core debug logic.
module jtag_tap_param #(
   parameter int          IR_WIDTH        = 5,
   parameter logic [31:0] IDCODE_VALUE    = 32'h0000_0001,
   parameter int          IDCODE_INSTR    = 1,
   parameter int          NUM_USER_DR     = 2,
   parameter int          USER_DR_WIDTH   = 32,
   parameter int          USER_INSTR_BASE = 2
) (
   input  logic                                   tck,
   input  logic                                   trst,
   input  logic                                   tms,
   input  logic                                   tdi,
   output logic                                   tdo,
   output logic                                   tdo_en,
   output logic [3:0]                             tap_state,
   output logic [IR_WIDTH-1:0]                    ir_out,
   output logic                                   test_logic_reset,
   output logic [NUM_USER_DR-1:0]                 user_sel,
   output logic [NUM_USER_DR-1:0]                 user_capture,
   input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_capture_data,
   output logic [NUM_USER_DR-1:0]                 user_update,
   output logic [USER_DR_WIDTH-1:0]               user_update_data
);

   typedef enum logic [3:0] {
      TLR     = 4'd0,
      RTI     = 4'd1,
      SEL_DR  = 4'd2,
      CAP_DR  = 4'd3,
      SH_DR   = 4'd4,
      EX1_DR  = 4'd5,
      PAUSE_DR = 4'd6,
      EX2_DR  = 4'd7,
      UPD_DR  = 4'd8,
      SEL_IR  = 4'd9,
      CAP_IR  = 4'd10,
      SH_IR   = 4'd11,
      EX1_IR  = 4'd12,
      PAUSE_IR = 4'd13,
      EX2_IR  = 4'd14,
      UPD_IR  = 4'd15
   } state_t;

   localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(IDCODE_INSTR);

   state_t                     state;
   state_t                     next_state;
   logic [IR_WIDTH-1:0]        ir_shift;
   logic                       bypass_reg;
   logic [31:0]                idcode_shift;
   logic [USER_DR_WIDTH-1:0]   user_shift;
   logic [USER_DR_WIDTH-1:0]   capture_word;
   logic                       sel_idcode;
   logic                       sel_user;
   logic                       clear_regs;

   always_ff @(posedge tck) begin
      if (trst) state <= TLR;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         TLR:      next_state = tms ? TLR    : RTI;
         RTI:      next_state = tms ? SEL_DR : RTI;
         SEL_DR:   next_state = tms ? SEL_IR : CAP_DR;
         CAP_DR:   next_state = tms ? EX1_DR : SH_DR;
         SH_DR:    next_state = tms ? EX1_DR : SH_DR;
         EX1_DR:   next_state = tms ? UPD_DR : PAUSE_DR;
         PAUSE_DR: next_state = tms ? EX2_DR : PAUSE_DR;
         EX2_DR:   next_state = tms ? UPD_DR : SH_DR;
         UPD_DR:   next_state = tms ? SEL_DR : RTI;
         SEL_IR:   next_state = tms ? TLR    : CAP_IR;
         CAP_IR:   next_state = tms ? EX1_IR : SH_IR;
         SH_IR:    next_state = tms ? EX1_IR : SH_IR;
         EX1_IR:   next_state = tms ? UPD_IR : PAUSE_IR;
         PAUSE_IR: next_state = tms ? EX2_IR : PAUSE_IR;
         EX2_IR:   next_state = tms ? UPD_IR : SH_IR;
         UPD_IR:   next_state = tms ? SEL_DR : RTI;
         default:  next_state = TLR;
      endcase
   end

   // All-ones wins over everything, then IDCODE; opcodes that would wrap past the IR range never select a channel.
   always_comb begin
      user_sel   = '0;
      sel_idcode = 1'b0;
      if (ir_out != '1) begin
         sel_idcode = (ir_out == IR_IDCODE);
         for (int k = 0; k < NUM_USER_DR; k++) begin
            if (!sel_idcode && ((USER_INSTR_BASE + k) < (1 << IR_WIDTH)) &&
                (ir_out == IR_WIDTH'(USER_INSTR_BASE + k)))
               user_sel[k] = 1'b1;
         end
      end
   end

   assign sel_user = |user_sel;

   always_comb begin
      capture_word = '0;
      for (int k = 0; k < NUM_USER_DR; k++) begin
         if (user_sel[k]) capture_word = user_capture_data[k*USER_DR_WIDTH +: USER_DR_WIDTH];
      end
   end

   // Entering Test-Logic-Reset by TMS clears the same state as trst.
   assign clear_regs = trst || (next_state == TLR);

   always_ff @(posedge tck) begin
      if (clear_regs) begin
         ir_shift <= '0;
         ir_out   <= IR_IDCODE;
      end else begin
         case (state)
            CAP_IR:  ir_shift <= IR_WIDTH'(1);
            SH_IR:   ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
            UPD_IR:  ir_out   <= ir_shift;
            default: ;
         endcase
      end
   end

   always_ff @(posedge tck) begin
      if (clear_regs) begin
         bypass_reg   <= 1'b0;
         idcode_shift <= '0;
         user_shift   <= '0;
      end else if (state == CAP_DR) begin
         bypass_reg <= 1'b0;
         if (sel_idcode) idcode_shift <= IDCODE_VALUE;
         if (sel_user)   user_shift   <= capture_word;
      end else if (state == SH_DR) begin
         if (sel_user)        user_shift   <= USER_DR_WIDTH'({tdi, user_shift} >> 1);
         else if (sel_idcode) idcode_shift <= {tdi, idcode_shift[31:1]};
         else                 bypass_reg   <= tdi;
      end
   end

   // user_update_data survives a TMS-driven reset; only trst clears it.
   always_ff @(posedge tck) begin
      if (trst) begin
         user_update      <= '0;
         user_update_data <= '0;
      end else begin
         user_update <= (state == UPD_DR) ? user_sel : '0;
         if (state == UPD_DR && sel_user) user_update_data <= user_shift;
      end
   end

   always_comb begin
      tdo = 1'b0;
      if (state == SH_IR)
         tdo = ir_shift[0];
      else if (state == SH_DR)
         tdo = sel_user ? user_shift[0] : (sel_idcode ? idcode_shift[0] : bypass_reg);
   end

   assign tdo_en           = (state == SH_IR) || (state == SH_DR);
   assign tap_state        = state;
   assign test_logic_reset = (state == TLR);
   assign user_capture     = (state == CAP_DR) ? user_sel : '0;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Testbench for jtag_tap_param: directed scenarios plus random TMS/TDI traffic,
// all checked against a queue-based behavioural model of the TAP.
module tb_jtag_tap_param;

   localparam int          IR_W     = 5;
   localparam int          NUM_U    = 2;
   localparam int          UW       = 32;
   localparam logic [31:0] IDV      = 32'h0000_0001;
   localparam int          ID_INSTR = 1;
   localparam int          U_BASE   = 2;

   logic                 tck = 1'b0;
   logic                 trst = 1'b1;
   logic                 tms = 1'b1;
   logic                 tdi = 1'b0;
   logic                 tdo;
   logic                 tdo_en;
   logic [3:0]           tap_state;
   logic [IR_W-1:0]      ir_out;
   logic                 test_logic_reset;
   logic [NUM_U-1:0]     user_sel;
   logic [NUM_U-1:0]     user_capture;
   logic [NUM_U*UW-1:0]  user_capture_data = '0;
   logic [NUM_U-1:0]     user_update;
   logic [UW-1:0]        user_update_data;

   int compared   = 0;
   int mismatched = 0;

   jtag_tap_param #(
      .IR_WIDTH(IR_W), .IDCODE_VALUE(IDV), .IDCODE_INSTR(ID_INSTR),
      .NUM_USER_DR(NUM_U), .USER_DR_WIDTH(UW), .USER_INSTR_BASE(U_BASE)
   ) dut (
      .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
      .tap_state(tap_state), .ir_out(ir_out), .test_logic_reset(test_logic_reset),
      .user_sel(user_sel), .user_capture(user_capture),
      .user_capture_data(user_capture_data), .user_update(user_update),
      .user_update_data(user_update_data)
   );

   always #5 tck = ~tck;

   // Reference model: state via transition tables, shift registers as bit queues (front = LSB = tdo).
   int         nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
   int         nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
   int         m_state;
   int         m_ir;
   bit         ir_q[$];
   bit         dr_q[$];
   logic [NUM_U-1:0] m_upd;
   logic [UW-1:0]    m_upd_data;
   bit         model_valid = 0;
   logic       last_tdo;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int decode(input int ir);
      if (ir == (1 << IR_W) - 1) return -1;
      if (ir == ID_INSTR) return -2;
      if (ir >= U_BASE && ir < U_BASE + NUM_U) return ir - U_BASE;
      return -1;
   endfunction

   task automatic model_step(input bit ms, input bit di, input bit rs, input logic [NUM_U*UW-1:0] cd);
      int sel;
      int ns;
      logic [UW-1:0] v;
      logic [31:0] idv;
      idv = IDV;
      sel = decode(m_ir);
      if (rs) begin
         m_state = 0; m_ir = ID_INSTR;
         ir_q.delete(); dr_q.delete();
         m_upd = '0; m_upd_data = '0;
         return;
      end
      ns = ms ? nxt1[m_state] : nxt0[m_state];
      m_upd = '0;
      case (m_state)
         3: begin
            dr_q.delete();
            if (sel == -1) dr_q.push_back(1'b0);
            else if (sel == -2) for (int i = 0; i < 32; i++) dr_q.push_back(idv[i]);
            else for (int i = 0; i < UW; i++) dr_q.push_back(cd[sel*UW + i]);
         end
         4: if (dr_q.size() > 0) begin
            void'(dr_q.pop_front());
            dr_q.push_back(di);
         end
         8: if (sel >= 0) begin
            v = '0;
            for (int i = 0; i < UW; i++) v[i] = dr_q[i];
            m_upd[sel] = 1'b1;
            m_upd_data = v;
         end
         10: begin
            ir_q.delete();
            for (int i = 0; i < IR_W; i++) ir_q.push_back(i == 0);
         end
         11: if (ir_q.size() > 0) begin
            void'(ir_q.pop_front());
            ir_q.push_back(di);
         end
         15: begin
            m_ir = 0;
            for (int i = 0; i < IR_W; i++) if (ir_q[i]) m_ir += (1 << i);
         end
         default: ;
      endcase
      if (ns == 0) begin
         m_ir = ID_INSTR;
         ir_q.delete(); dr_q.delete();
      end
      m_state = ns;
   endtask

   task automatic compare_all();
      int sel;
      logic [NUM_U-1:0] esel;
      logic etdo;
      sel  = decode(m_ir);
      esel = (sel >= 0) ? NUM_U'(1 << sel) : '0;
      etdo = 1'b0;
      if (m_state == 11 && ir_q.size() > 0) etdo = ir_q[0];
      if (m_state == 4 && dr_q.size() > 0)  etdo = dr_q[0];
      checkOutput("tap_state", 64'(tap_state), 64'(m_state));
      checkOutput("test_logic_reset", 64'(test_logic_reset), 64'(m_state == 0));
      checkOutput("ir_out", 64'(ir_out), 64'(m_ir));
      checkOutput("tdo", 64'(tdo), 64'(etdo));
      checkOutput("tdo_en", 64'(tdo_en), 64'(m_state == 4 || m_state == 11));
      checkOutput("user_sel", 64'(user_sel), 64'(esel));
      checkOutput("user_capture", 64'(user_capture), 64'((m_state == 3) ? esel : '0));
      checkOutput("user_update", 64'(user_update), 64'(m_upd));
      checkOutput("user_update_data", 64'(user_update_data), 64'(m_upd_data));
   endtask

   // One tck: drive inputs, compare against the model, clock, advance the model.
   task automatic applyStimulus(input bit ms, input bit di, input bit rs);
      tms = ms; tdi = di; trst = rs;
      #1;
      last_tdo = tdo;
      if (model_valid) compare_all();
      @(posedge tck);
      model_step(ms, di, rs, user_capture_data);
      model_valid = 1;
      @(negedge tck);
   endtask

   // From RTI: load an instruction, return the bits shifted out, finish in RTI.
   task automatic load_ir(input logic [IR_W-1:0] v, output logic [IR_W-1:0] cap);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      for (int i = 0; i < IR_W; i++) begin
         applyStimulus(i == IR_W - 1, v[i], 0);
         cap[i] = last_tdo;
      end
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
   endtask

   // From RTI: capture/shift n DR bits; returns in the cycle after the Update-DR edge.
   task automatic shift_dr(input int n, input logic [31:0] data, output logic [31:0] got,
                           output logic [NUM_U-1:0] cap_seen);
      got = '0;
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      #1 cap_seen = user_capture;
      applyStimulus(0, 0, 0);
      for (int i = 0; i < n; i++) begin
         applyStimulus(i == n - 1, data[i], 0);
         got[i] = last_tdo;
      end
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
   endtask

   task automatic check_tlr(input string tag);
      #1;
      checkOutput({tag, "_state"}, 64'(tap_state), 64'd0);
      checkOutput({tag, "_tlr"}, 64'(test_logic_reset), 64'd1);
      checkOutput({tag, "_ir"}, 64'(ir_out), 64'(ID_INSTR));
   endtask

   initial begin
      logic [IR_W-1:0]  cap;
      logic [31:0]      got;
      logic [NUM_U-1:0] capt;

      user_capture_data = {$urandom, $urandom};

      applyStimulus(1, 0, 1);
      #1;
      checkOutput("rst_state", 64'(tap_state), 64'd0);
      checkOutput("rst_tlr", 64'(test_logic_reset), 64'd1);
      checkOutput("rst_ir", 64'(ir_out), 64'(ID_INSTR));
      checkOutput("rst_tdo_en", 64'(tdo_en), 64'd0);
      checkOutput("rst_user_sel", 64'(user_sel), 64'd0);
      checkOutput("rst_upd_data", 64'(user_update_data), 64'd0);

      applyStimulus(0, 0, 0);
      shift_dr(32, $urandom, got, capt);
      checkOutput("idcode_stream", 64'(got), 64'h0000_0001);
      checkOutput("idcode_ir", 64'(ir_out), 64'(ID_INSTR));

      load_ir(5'h1F, cap);
      #1 checkOutput("ir_bypass_loaded", 64'(ir_out), 64'h1F);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
      check_tlr("tlr_from_shdr");

      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
      check_tlr("tlr_from_shir");

      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
      check_tlr("tlr_from_pauseir");

      applyStimulus(0, 0, 0);
      load_ir(5'h1F, cap);
      checkOutput("ir_capture_bits", 64'(cap), 64'h01);
      #1 checkOutput("bypass_ir", 64'(ir_out), 64'h1F);
      shift_dr(4, 32'hD, got, capt);
      checkOutput("bypass_delay", 64'(got[3:0]), 64'hA);

      load_ir(5'h1C, cap);
      #1 checkOutput("undef_user_sel", 64'(user_sel), 64'd0);
      shift_dr(4, 32'hD, got, capt);
      checkOutput("undef_bypass", 64'(got[3:0]), 64'hA);

      load_ir(5'h02, cap);
      #1 checkOutput("user0_sel", 64'(user_sel), 64'h1);
      user_capture_data = {$urandom, 32'hA5A5_0F0F};
      shift_dr(32, 32'h1234_5678, got, capt);
      checkOutput("user0_capture_pulse", 64'(capt), 64'h1);
      checkOutput("user0_tdo_stream", 64'(got), 64'hA5A5_0F0F);
      #1;
      checkOutput("user0_update_pulse", 64'(user_update), 64'h1);
      checkOutput("user0_update_data", 64'(user_update_data), 64'h1234_5678);

      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      for (int i = 0; i < 10; i++) applyStimulus(0, 1'($urandom), 0);
      applyStimulus(0, 0, 1);
      #1;
      checkOutput("trst_state", 64'(tap_state), 64'd0);
      checkOutput("trst_ir", 64'(ir_out), 64'(ID_INSTR));
      checkOutput("trst_no_update", 64'(user_update), 64'd0);
      checkOutput("trst_upd_data", 64'(user_update_data), 64'd0);
      applyStimulus(0, 0, 0);

      for (int c = 0; c < 3000; c++) begin
         user_capture_data = {$urandom, $urandom};
         applyStimulus($urandom_range(0, 9) < 4, 1'($urandom), $urandom_range(0, 199) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
